uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver. It captures each completed character from the receiver's one-cycle completion pulses: good data, framing error or parity error.
- Each character is stored with its error status in a circular FIFO.
- The FIFO is presented to the host/bus side through a valid/ready first-word-fall-through read port.
- Also provides occupancy, almost-full and sticky overrun status.

---
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: stores each completed character
// with its framing/parity status and presents it on a first-word-fall-through port.
module uart_rx_fifo #(
  parameter int DBITS     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic [DBITS-1:0]           rx_data,
  input  logic                       rx_valid,
  input  logic                       framing_err,
  input  logic                       parity_err,
  input  logic                       flush,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DBITS-1:0]           rd_data,
  output logic                       rd_ferr,
  output logic                       rd_perr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DBITS+1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overrun;

  logic             w_wr_ev;
  logic             w_rd_hs;
  logic             w_wr_acc;
  logic             w_ovr_set;
  logic             w_full;
  logic             w_empty;
  logic [DBITS+1:0] w_head;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_wr_ev   = rx_valid | framing_err | parity_err;
  assign w_rd_hs   = ~w_empty & rd_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr_acc  = w_wr_ev & (~w_full | w_rd_hs);
  // A flushed write is discarded outright, so it cannot register as an overrun.
  assign w_ovr_set = w_wr_ev & w_full & ~w_rd_hs & ~flush;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_hs)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_hs})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst && !flush && w_wr_acc)
      r_mem[r_wr_ptr] <= {parity_err, framing_err, rx_data};
  end

  always_ff @(posedge sysclk) begin
    if (rst)              r_overrun <= 1'b0;
    else if (w_ovr_set)   r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_valid    = ~w_empty;
  assign rd_data     = w_head[DBITS-1:0];
  assign rd_ferr     = w_head[DBITS];
  assign rd_perr     = w_head[DBITS+1];
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= CW'(AFULL_LVL));
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table for the corner cases, then
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DBITS = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       sysclk = 1'b0;
  logic       rst, rx_valid, framing_err, parity_err, flush, rd_ready, clr_overrun;
  logic [7:0] rx_data;
  logic       rd_valid, rd_ferr, rd_perr, full, empty, almost_full, overrun;
  logic [7:0] rd_data;
  logic [4:0] count;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 sysclk = ~sysclk;

  uart_rx_fifo #(.DBITS(DBITS), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .sysclk(sysclk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .framing_err(framing_err), .parity_err(parity_err), .flush(flush),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ferr(rd_ferr), .rd_perr(rd_perr), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  typedef struct {
    logic       rst, rxv, fe, pe, rdy, fl, clr;
    logic [7:0] d;
    int         e_cnt;
    logic       e_val;
    logic [7:0] e_data;
    logic       e_fe, e_pe, e_ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic v, logic f, logic p, logic [7:0] d,
                              logic rdy, logic fl, logic clr, int cnt, logic val,
                              logic [7:0] ed, logic efe, logic epe, logic eovr);
    vec_t t;
    t.rst = r; t.rxv = v; t.fe = f; t.pe = p; t.d = d;
    t.rdy = rdy; t.fl = fl; t.clr = clr;
    t.e_cnt = cnt; t.e_val = val; t.e_data = ed;
    t.e_fe = efe; t.e_pe = epe; t.e_ovr = eovr;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input logic val,
                           input logic [7:0] d, input logic fe, input logic pe,
                           input logic ovr);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(val));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(d));
    chk({tag, ".rd_ferr"}, 32'(rd_ferr), 32'(fe));
    chk({tag, ".rd_perr"}, 32'(rd_perr), 32'(pe));
    chk({tag, ".full"}, 32'(full), 32'(cnt == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= AFULL));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
  endtask

  task automatic drive(input logic r, input logic v, input logic f, input logic p,
                       input logic [7:0] d, input logic rdy, input logic fl,
                       input logic clr);
    rst = r; rx_valid = v; framing_err = f; parity_err = p; rx_data = d;
    rd_ready = rdy; flush = fl; clr_overrun = clr;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Reference model state
  logic [9:0] mq[$];
  logic       m_ovr;

  task automatic model_step(input logic r, input logic v, input logic f, input logic p,
                            input logic [7:0] d, input logic rdy, input logic fl,
                            input logic clr);
    logic was_full, hs, wr, set;
    was_full = (mq.size() == DEPTH);
    hs  = (mq.size() != 0) && rdy;
    wr  = v | f | p;
    set = 1'b0;
    if (r) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      if (fl) mq.delete();
      else begin
        if (hs) void'(mq.pop_front());
        if (wr) begin
          if (!was_full || hs) mq.push_back({p, f, d});
          else set = 1'b1;
        end
      end
      if (set) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    tick();
    tick();
    check_all("reset", 0, 0, 8'h00, 0, 0, 0);

    // Directed vectors
    add(0,1,0,0,8'h41,0,0,0, 1,1,8'h41,0,0,0);
    add(0,1,0,0,8'h42,0,0,0, 2,1,8'h41,0,0,0);
    add(0,1,0,0,8'h43,0,0,0, 3,1,8'h41,0,0,0);
    add(0,0,0,0,8'h00,1,0,0, 2,1,8'h42,0,0,0);
    add(0,0,0,0,8'h00,1,0,0, 1,1,8'h43,0,0,0);
    add(0,0,0,0,8'h00,1,0,0, 0,0,8'h00,0,0,0);
    add(0,0,0,0,8'h00,1,0,0, 0,0,8'h00,0,0,0);
    add(0,0,1,0,8'h7F,0,0,0, 1,1,8'h7F,1,0,0);
    add(0,0,0,1,8'h10,0,0,0, 2,1,8'h7F,1,0,0);
    add(0,0,0,0,8'h00,1,0,0, 1,1,8'h10,0,1,0);
    add(0,0,0,0,8'h00,1,0,0, 0,0,8'h00,0,0,0);
    add(0,1,1,1,8'h99,0,0,0, 1,1,8'h99,1,1,0);
    add(0,0,0,0,8'h00,1,0,0, 0,0,8'h00,0,0,0);
    for (int i = 0; i < DEPTH; i++)
      add(0,1,0,0,8'(i),0,0,0, i+1,1,8'h00,0,0,0);
    add(0,1,0,0,8'hAA,0,0,0, 16,1,8'h00,0,0,1);
    add(0,0,0,0,8'h00,0,0,1, 16,1,8'h00,0,0,0);
    add(0,1,0,0,8'h55,1,0,0, 16,1,8'h01,0,0,0);
    for (int k = 1; k <= 15; k++)
      add(0,0,0,0,8'h00,1,0,0, 16-k,1,(k < 15) ? 8'(k+1) : 8'h55,0,0,0);
    add(0,0,0,0,8'h00,1,0,0, 0,0,8'h00,0,0,0);
    for (int j = 0; j < 20; j++)
      add(0,1,0,0,8'(8'h80+j),1,0,0, 1,1,8'(8'h80+j),0,0,0);
    add(0,1,0,0,8'hEE,1,1,0, 0,0,8'h00,0,0,0);
    for (int i = 0; i < DEPTH; i++)
      add(0,1,0,0,8'(8'h20+i),0,0,0, i+1,1,8'h20,0,0,0);
    add(0,1,0,0,8'hBB,0,0,0, 16,1,8'h20,0,0,1);
    add(0,0,0,0,8'h00,0,1,0, 0,0,8'h00,0,0,1);
    for (int i = 0; i < 5; i++)
      add(0,1,0,0,8'(8'h30+i),0,0,0, i+1,1,8'h30,0,0,1);
    add(1,1,0,0,8'hCC,1,0,0, 0,0,8'h00,0,0,0);

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].rst, vecs[n].rxv, vecs[n].fe, vecs[n].pe, vecs[n].d,
            vecs[n].rdy, vecs[n].fl, vecs[n].clr);
      tick();
      check_all($sformatf("vec%0d", n), vecs[n].e_cnt, vecs[n].e_val,
                vecs[n].e_data, vecs[n].e_fe, vecs[n].e_pe, vecs[n].e_ovr);
    end

    // Hand sequence: set and clear of overrun in the same cycle, set wins
    drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 0, 8'(8'h60+i), 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0, 8'hDD, 0, 0, 1);
    tick();
    check_all("set_vs_clr", 16, 1, 8'h60, 0, 0, 1);
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    tick();
    check_all("rst2", 0, 0, 8'h00, 0, 0, 0);

    // Randomized traffic against the queue model
    mq.delete();
    m_ovr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic r, v, f, p, rdy, fl, clr;
      logic [7:0] d;
      int unsigned rdy_pct;
      rdy_pct = ((c / 250) % 3 == 0) ? 15 : (((c / 250) % 3 == 1) ? 50 : 85);
      r   = ($urandom_range(0, 499) == 0);
      fl  = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 19) == 0);
      v   = ($urandom_range(0, 99) < 50);
      f   = ($urandom_range(0, 99) < 8);
      p   = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      d   = 8'($urandom);
      drive(r, v, f, p, d, rdy, fl, clr);
      model_step(r, v, f, p, d, rdy, fl, clr);
      tick();
      if (mq.size() != 0)
        check_all("rand", mq.size(), 1, mq[0][7:0], mq[0][8], mq[0][9], m_ovr);
      else
        check_all("rand", 0, 0, 8'h00, 0, 0, m_ovr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
